// File: rtl/stopwatch_controller_if.sv
// Signal bundle between the stopwatch control FSM and its surroundings
// (100 Hz divider, BCD counter chain, LED display latch, push-buttons).
interface stopwatch_controller_if;
    logic       tick_in;
    logic       at_max;
    logic       btn_start_stop;
    logic       btn_lap_clear;
    logic       tick_en;
    logic       clr;
    logic       hold;
    logic [1:0] state;

    // No valid/ready handshake: tick_in, tick_en and clr are one-cycle
    // strobes that are acted on in the cycle they are high.
    // hold and state are levels.
    modport master (
        input  tick_in,
        input  at_max,
        input  btn_start_stop,
        input  btn_lap_clear,
        output tick_en,
        output clr,
        output hold,
        output state
    );

    modport slave (
        output tick_in,
        output at_max,
        output btn_start_stop,
        output btn_lap_clear,
        input  tick_en,
        input  clr,
        input  hold,
        input  state
    );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch control FSM: synchronizes and debounces two buttons, gates the
// 100 Hz tick into the BCD chain, and drives clear and display lap-hold.
module stopwatch_controller #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   CLK_50M,
    input  logic                   RST_N,
    stopwatch_controller_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_LAP  = 2'b10,
        S_STOP = 2'b11
    } state_t;

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Index 0 is start_stop, index 1 is lap_clear.
    logic [1:0]    btn_raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;

    state_t state_q;
    state_t state_d;
    logic   clr_d;
    logic   clr_q;
    logic   hold_q;
    logic   tick_en_q;
    logic   running;

    assign btn_raw = {bus.btn_lap_clear, bus.btn_start_stop};

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 2; i++) cnt[i] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_d <= deb;
            // Level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != deb[i]) begin
                    if (cnt[i] == CNT_LAST) begin
                        deb[i] <= ~deb[i];
                        cnt[i] <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign press   = deb & ~deb_d;
    assign running = (state_q == S_RUN) || (state_q == S_LAP);

    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (press[0]) begin
                    state_d = S_RUN;
                end else if (press[1]) begin
                    clr_d = 1'b1;
                end
            end
            S_RUN: begin
                // Saturation outranks both buttons so the count never wraps.
                if (bus.at_max || press[0]) begin
                    state_d = S_STOP;
                end else if (press[1]) begin
                    state_d = S_LAP;
                end
            end
            S_LAP: begin
                if (bus.at_max || press[0]) begin
                    state_d = S_STOP;
                end else if (press[1]) begin
                    state_d = S_RUN;
                end
            end
            S_STOP: begin
                if (press[0]) begin
                    state_d = S_RUN;
                end else if (press[1]) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            clr_q     <= 1'b0;
            hold_q    <= 1'b0;
            tick_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            hold_q    <= (state_d == S_LAP);
            tick_en_q <= bus.tick_in & running & ~bus.at_max;
        end
    end

    assign bus.state   = state_q;
    assign bus.clr     = clr_q;
    assign bus.hold    = hold_q;
    assign bus.tick_en = tick_en_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller with DEBOUNCE_CYCLES=4 and a
// tick_in strobe every 10 cycles.
module tb_stopwatch_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    stopwatch_controller_if sw_if ();

    stopwatch_controller #(.DEBOUNCE_CYCLES(4)) dut (
        .CLK_50M (clk),
        .RST_N   (rst_n),
        .bus     (sw_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       ss;
        logic       lc;
        logic [1:0] exp_state;
        logic       exp_hold;
        int         exp_clr;
        bit         exp_ticks;
    } vec_t;

    vec_t vecs [11];

    int n_tests        = 0;
    int n_fail         = 0;
    int tick_phase     = 0;
    int tick_seen      = 0;
    int tick_hit       = 0;
    int spurious_total = 0;
    int clr_cnt        = 0;
    int run_cycles     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: drive tick_in for this cycle, then sample just after the edge.
    task automatic step();
        sw_if.tick_in = (tick_phase == 9);
        tick_phase    = (tick_phase + 1) % 10;
        @(posedge clk);
        #1;
        if (sw_if.tick_in) begin
            tick_seen++;
            if (sw_if.tick_en) tick_hit++;
        end else if (sw_if.tick_en) begin
            spurious_total++;
        end
        if (sw_if.clr) clr_cnt++;
        if (sw_if.state == 2'b01) run_cycles++;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic press(input logic ss, input logic lc);
        sw_if.btn_start_stop = ss;
        sw_if.btn_lap_clear  = lc;
        steps(8);
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;
        steps(8);
    endtask

    task automatic tick_window(input string name, input bit on);
        tick_seen = 0;
        tick_hit  = 0;
        steps(30);
        check(name, tick_hit, on ? tick_seen : 0);
    endtask

    initial begin
        sw_if.tick_in        = 1'b0;
        sw_if.at_max         = 1'b0;
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;

        //                ss    lc    state  hold  clr ticks
        vecs[0]  = '{1'b0, 1'b1, 2'b10, 1'b1, 0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 2'b11, 1'b0, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 2'b00, 1'b0, 1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 1'b1, 0, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'b11, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b1};

        // Reset held for 3 edges with inputs toggling.
        for (int k = 0; k < 3; k++) begin
            sw_if.btn_start_stop = (k % 2 == 0);
            sw_if.btn_lap_clear  = (k % 2 == 1);
            sw_if.tick_in        = (k % 2 == 0);
            @(posedge clk);
            #1;
            check($sformatf("rst%0d_state", k), sw_if.state, 0);
            check($sformatf("rst%0d_tick_en", k), sw_if.tick_en, 0);
            check($sformatf("rst%0d_clr", k), sw_if.clr, 0);
            check($sformatf("rst%0d_hold", k), sw_if.hold, 0);
        end
        sw_if.btn_start_stop = 1'b0;
        sw_if.btn_lap_clear  = 1'b0;
        rst_n = 1'b1;
        step();
        check("rel_state", sw_if.state, 0);
        check("rel_tick_en", sw_if.tick_en, 0);
        check("rel_clr", sw_if.clr, 0);
        check("rel_hold", sw_if.hold, 0);
        steps(10);

        // Bounce shorter than the debounce window.
        tick_seen = 0;
        tick_hit  = 0;
        for (int k = 0; k < 8; k++) begin
            sw_if.btn_start_stop = ((k / 2) % 2 == 0);
            step();
        end
        sw_if.btn_start_stop = 1'b0;
        steps(12);
        check("bounce_state", sw_if.state, 0);
        check("bounce_ticks", tick_hit, 0);

        // Start press latency: state changes 6 edges after first high sample.
        sw_if.btn_start_stop = 1'b1;
        steps(6);
        check("start_not_early", sw_if.state, 0);
        step();
        check("start_latency", sw_if.state, 1);
        step();
        sw_if.btn_start_stop = 1'b0;
        steps(8);
        tick_window("run_ticks", 1'b1);

        for (int i = 0; i < 11; i++) begin
            clr_cnt = 0;
            press(vecs[i].ss, vecs[i].lc);
            check($sformatf("vec%0d_state", i), sw_if.state, vecs[i].exp_state);
            check($sformatf("vec%0d_hold", i), sw_if.hold, vecs[i].exp_hold);
            check($sformatf("vec%0d_clr", i), clr_cnt, vecs[i].exp_clr);
            tick_window($sformatf("vec%0d_ticks", i), vecs[i].exp_ticks);
        end

        // Saturation in RUN, at_max rising in the same cycle as tick_in.
        for (int k = 0; k < 10 && tick_phase != 9; k++) step();
        sw_if.at_max = 1'b1;
        tick_seen = 0;
        tick_hit  = 0;
        step();
        check("sat_tick_seen", tick_seen, 1);
        check("sat_tick_gated", tick_hit, 0);
        check("sat_state", sw_if.state, 3);
        check("sat_hold", sw_if.hold, 0);
        run_cycles = 0;
        press(1'b1, 1'b0);
        check("sat_resume_run_cycles", run_cycles, 1);
        check("sat_resume_state", sw_if.state, 3);
        sw_if.at_max = 1'b0;

        // Saturation while in LAP drops hold.
        press(1'b1, 1'b0);
        check("lapsat_run", sw_if.state, 1);
        press(1'b0, 1'b1);
        check("lapsat_lap", sw_if.state, 2);
        check("lapsat_hold_hi", sw_if.hold, 1);
        sw_if.at_max = 1'b1;
        step();
        check("lapsat_state", sw_if.state, 3);
        check("lapsat_hold_lo", sw_if.hold, 0);
        sw_if.at_max = 1'b0;

        // Reset mid-run: immediate IDLE, no clr.
        press(1'b1, 1'b0);
        check("midrst_run", sw_if.state, 1);
        clr_cnt = 0;
        rst_n = 1'b0;
        step();
        check("midrst_state", sw_if.state, 0);
        check("midrst_clr", clr_cnt, 0);
        check("midrst_tick_en", sw_if.tick_en, 0);

        // Button held through reset release.
        sw_if.btn_start_stop = 1'b1;
        step();
        rst_n = 1'b1;
        steps(6);
        check("held_rst_not_early", sw_if.state, 0);
        step();
        check("held_rst_press", sw_if.state, 1);
        sw_if.btn_start_stop = 1'b0;
        steps(10);

        check("no_spurious_tick_en", spurious_total, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
